// File: rtl/mat_serializer.sv
// Captures a ROWS x COLS matrix on start and streams its elements over a valid/ready port.
// Define MAT_SERIALIZER_COLMAJOR_EN for column-major traversal; row-major otherwise.
module mat_serializer #(
    parameter int ROWS  = 1,
    parameter int COLS  = 1,
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ROWS*COLS*WIDTH-1:0]  mat_in,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);
    localparam int N  = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [N*WIDTH-1:0]   mat_q;
    logic [RW-1:0]        row, nrow;
    logic [CW-1:0]        col, ncol;
    logic [WIDTH-1:0]     ndata;
    logic                 nlast;

    // Next position; the wrapped value past the final element is never presented.
    always_comb begin
        nrow = row;
        ncol = col;
`ifdef MAT_SERIALIZER_COLMAJOR_EN
        if (row == ROW_MAX) begin
            nrow = '0;
            ncol = col + 1'b1;
        end else begin
            nrow = row + 1'b1;
        end
`else
        if (col == COL_MAX) begin
            ncol = '0;
            nrow = row + 1'b1;
        end else begin
            ncol = col + 1'b1;
        end
`endif
        ndata = mat_q[(int'(nrow) * COLS + int'(ncol)) * WIDTH +: WIDTH];
        nlast = (nrow == ROW_MAX) && (ncol == COL_MAX);
    end

    assign busy = (state == SEND);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mat_q     <= '0;
            row       <= '0;
            col       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mat_q     <= mat_in;
                        row       <= '0;
                        col       <= '0;
                        out_data  <= mat_in[WIDTH-1:0];
                        out_valid <= 1'b1;
                        out_last  <= (N == 1);
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            row      <= nrow;
                            col      <= ncol;
                            out_data <= ndata;
                            out_last <= nlast;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_serializer.sv
// Randomized scoreboard bench for mat_serializer (2x2 instance plus a 1x1 instance).
module tb_mat_serializer;
    localparam int R = 2, C = 2, W = 8;

    logic             clk = 0, reset = 1, start = 0, out_ready = 0;
    logic [R*C*W-1:0] mat_in = '0;
    logic [W-1:0]     out_data;
    logic             out_valid, out_last, busy, done;

    logic         one_start = 0, one_ready = 0;
    logic [W-1:0] one_mat = '0, one_data;
    logic         one_valid, one_last, one_busy, one_done;

    int vectors = 0, miscompares = 0;

    typedef struct { logic [W-1:0] data; logic last; } beat_t;
    beat_t q[$];
    bit    done_pending = 0;

    mat_serializer #(.ROWS(R), .COLS(C), .WIDTH(W)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mat_in(mat_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done));

    mat_serializer #(.ROWS(1), .COLS(1), .WIDTH(W)) u_one (
        .clk(clk), .reset(reset), .start(one_start), .mat_in(one_mat),
        .out_data(one_data), .out_valid(one_valid), .out_ready(one_ready),
        .out_last(one_last), .busy(one_busy), .done(one_done));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference order: element (r,c) of the packed matrix, visited in the configured order.
    task automatic push_expected(input logic [R*C*W-1:0] m);
        logic [W-1:0] e;
`ifdef MAT_SERIALIZER_COLMAJOR_EN
        for (int c = 0; c < C; c++)
            for (int r = 0; r < R; r++) begin
`else
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
`endif
                e = m[(r*C + c)*W +: W];
                q.push_back('{data: e, last: (r == R-1) && (c == C-1)});
            end
    endtask

    // Monitor: compares every presented beat (held or accepted) against the queue head.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            done_pending = 0;
        end else begin
            if (done_pending) begin
                check("done_pulse", {done, out_valid, busy}, 3'b100);
                done_pending = 0;
            end else if (done) begin
                check("spurious_done", done, 1'b0);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", out_valid, 1'b0);
                end else begin
                    check("beat_data", out_data, q[0].data);
                    check("beat_last", out_last, q[0].last);
                    if (out_ready) begin
                        if (q[0].last) done_pending = 1;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // mode 0: ready high, 1: ready toggling, 2: random ready.
    task automatic run_2x2(input logic [R*C*W-1:0] m, input int mode, input bit inject,
                           input bit abort_after2);
        int  hs = 0, cyc = 0;
        bit  fin = 0;
        bit  tog = 1;
        @(posedge clk); #1;
        mat_in = m;
        push_expected(m);
        start = 1;
        out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 0;
        check("latency_valid", out_valid, 1'b1);
        if (out_valid && out_ready) hs++;
        for (cyc = 1; cyc < 60; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                start = 0;
                fin = 1;
                break;
            end
            if (abort_after2 && hs == 2) begin
                reset = 1;
                start = 0;
                #1;
                check("abort_valid_busy", {out_valid, busy, done}, 3'b000);
                @(posedge clk); #1;
                reset = 0;
                return;
            end
            if (inject) begin
                start  = 1'($urandom_range(0, 1));
                mat_in = '1;
            end
            tog = ~tog;
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            if (out_valid && out_ready) hs++;
        end
        check("transfer_completed", fin, 1'b1);
        if (mode == 0) check("cycles_per_matrix", cyc, R*C);
        @(posedge clk); #1;
        check("queue_drained", q.size(), 0);
        check("idle_after_done", {busy, out_valid, out_last}, 3'b000);
    endtask

    initial begin
        #1;
        check("reset_state", {out_valid, out_last, busy, done}, 4'b0000);
        check("reset_data", out_data, 0);
        @(posedge clk); #1;
        reset = 0;

        run_2x2({8'h04, 8'h03, 8'h02, 8'h01}, 0, 0, 0);
        run_2x2({8'h04, 8'h03, 8'h02, 8'h01}, 1, 0, 0);
        run_2x2({8'h04, 8'h03, 8'h02, 8'h01}, 0, 0, 1);
        run_2x2({8'h04, 8'h03, 8'h02, 8'h01}, 0, 0, 0);
        run_2x2({8'h04, 8'h03, 8'h02, 8'h01}, 2, 1, 0);
        run_2x2({8'h80, 8'hFF, 8'h00, 8'h7F}, 1, 1, 0);
        for (int i = 0; i < 12; i++)
            run_2x2($urandom(), i % 3, i[0], (i == 5));

        // Single-element matrix.
        @(posedge clk); #1;
        one_mat = 8'hA5;
        one_start = 1;
        @(posedge clk); #1;
        one_start = 0;
        one_mat = 8'h00;
        check("one_valid", one_valid, 1'b1);
        check("one_data", one_data, 8'hA5);
        check("one_last", one_last, 1'b1);
        one_ready = 1;
        @(posedge clk); #1;
        one_ready = 0;
        check("one_done", {one_done, one_valid, one_busy}, 3'b100);
        @(posedge clk); #1;
        check("one_done_pulse", one_done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mat_serializer.md
MAT_SERIALIZER -- requirements
Module: mat_serializer

Interface
REQ-001 The block SHALL have parameter ROWS, default 1, giving the number of matrix rows.
REQ-002 The block SHALL have parameter COLS, default 1, giving the number of matrix columns.
REQ-003 The block SHALL have parameter WIDTH, default 8, giving the element width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, the asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit, a request to capture mat_in and begin streaming.
REQ-007 The block SHALL have port mat_in, input, ROWS*COLS*WIDTH bits, the packed matrix; element (r,c) SHALL occupy bits [(r*COLS+c)*WIDTH +: WIDTH].
REQ-008 The block SHALL have port out_data, output, WIDTH bits, the current element.
REQ-009 The block SHALL have port out_valid, output, 1 bit, asserted when out_data holds an element.
REQ-010 The block SHALL have port out_ready, input, 1 bit, the sink acceptance signal.
REQ-011 The block SHALL have port out_last, output, 1 bit, marking the final element of the matrix.
REQ-012 The block SHALL have port busy, output, 1 bit, high while a transfer is in progress.
REQ-013 The block SHALL have port done, output, 1 bit, a one-cycle pulse on transfer completion.

Function
REQ-014 The block SHALL use a two-state FSM: IDLE and SEND.
REQ-015 In IDLE, start=1 at a rising edge SHALL copy mat_in into an internal register, zero the row/column indices, and move to SEND.
REQ-016 out_valid SHALL rise in the cycle after start is sampled, presenting element (0,0); the latency is one cycle.
REQ-017 A handshake SHALL occur at a rising edge where out_valid=1 and out_ready=1.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-019 On each handshake the indices SHALL advance in row-major order: the column increments and wraps to 0 at COLS-1 with a row increment.
REQ-020 With out_ready held high, one element SHALL transfer per cycle, completing in exactly ROWS*COLS cycles.
REQ-021 out_last SHALL be 1 only while the final element (ROWS-1,COLS-1) is presented.
REQ-022 A handshake on the final element SHALL return the FSM to IDLE, drop out_valid and busy in the next cycle, and pulse done for exactly that one cycle.
REQ-023 busy SHALL equal 1 exactly when the state is SEND.
REQ-024 start asserted while in SEND, including the cycle of the final handshake, SHALL be ignored; the captured matrix is unaffected.
REQ-025 Changes on mat_in after capture SHALL NOT affect the streamed data.
REQ-026 For ROWS=COLS=1 the single element SHALL carry out_last=1.
REQ-027 Elements SHALL be passed bit-exact, with no sign extension or truncation.

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE, out_valid=0, out_last=0, busy=0, done=0, out_data=0, the indices to 0, and the captured matrix to 0.
REQ-029 Reset in the middle of a transfer SHALL abandon that transfer with no done pulse; a subsequent start SHALL begin again from (0,0).

Configuration
REQ-030 With macro MAT_SERIALIZER_COLMAJOR_EN defined, traversal SHALL be column-major: the row increments first, wrapping at ROWS-1 with a column increment.
REQ-031 Without MAT_SERIALIZER_COLMAJOR_EN, traversal SHALL be row-major per REQ-019.
REQ-032 In both modes out_last SHALL mark element (ROWS-1,COLS-1), and completion timing SHALL be identical.

Verification
REQ-033 ROWS=2, COLS=2, WIDTH=8, mat_in={8'h04,8'h03,8'h02,8'h01}, start pulse, out_ready=1 -> out_data 01,02,03,04 on four consecutive cycles, out_last on 04, and done pulsing the next cycle.
REQ-034 The same matrix with out_ready toggling 1,0,1,0,... -> the same sequence, data held stable during stalls, done after the fourth handshake.
REQ-035 reset asserted after two handshakes -> out_valid=0 and busy=0 immediately with no done pulse; a new start then emits 01 first.
REQ-036 start re-asserted during SEND and mat_in changed to all FF -> the stream remains 01,02,03,04.
REQ-037 MAT_SERIALIZER_COLMAJOR_EN defined, same 2x2 stimulus -> order 01,03,02,04, with out_last on 04.
REQ-038 ROWS=COLS=1, mat_in=8'hA5 -> a single beat of A5 with out_last=1, then done.
